// File: rtl/regfile_context_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regfile_context_sequencer
// Brief    : Saves/restores register context between the register file and memory.
// Revision : 1.0
// ============================================================================
module regfile_context_sequencer #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_start,
    input  logic              restore_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              rf_own,
    output logic [4:0]        rf_ra1,
    input  logic [31:0]       rf_rd1,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [31:0]       rf_wd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_save   = 3'd1;
    localparam logic [2:0] c_rst_rd = 3'd2;
    localparam logic [2:0] c_rst_wr = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    localparam logic [4:0] c_first = 5'(FIRST_REG);
    localparam logic [4:0] c_last  = 5'(LAST_REG);

    logic [2:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;

    logic [4:0]        w_idx_off;
    logic [ADDR_W-1:0] w_addr;

    // Word offset from the save-area base; the add wraps modulo 2^ADDR_W.
    assign w_idx_off = idx_q - c_first;
    assign w_addr    = base_q + ADDR_W'({w_idx_off, 2'b00});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = data_q;
        case (state_q)
            c_idle: begin
                if (save_start || restore_start) begin
                    state_d = save_start ? c_save : c_rst_rd;
                    base_d  = {base_addr[ADDR_W-1:2], 2'b00};
                    idx_d   = c_first;
                end
            end
            c_save: begin
                if (mem_ready) begin
                    if (idx_q == c_last) state_d = c_done;
                    else                 idx_d   = idx_q + 5'd1;
                end
            end
            c_rst_rd: begin
                if (mem_ready) begin
                    data_d  = mem_rdata;
                    state_d = c_rst_wr;
                end
            end
            c_rst_wr: begin
                if (idx_q == c_last) begin
                    state_d = c_done;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = c_rst_rd;
                end
            end
            c_done:  state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_idle;
            idx_q   <= c_first;
            base_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode purely from registered state, so an async reset clears them at once.
    always_comb begin
        busy      = (state_q != c_idle);
        rf_own    = busy;
        done      = (state_q == c_done);
        mem_req   = (state_q == c_save) || (state_q == c_rst_rd);
        mem_we    = (state_q == c_save);
        mem_addr  = mem_req ? w_addr : '0;
        rf_ra1    = (state_q == c_save) ? idx_q : 5'd0;
        mem_wdata = (state_q == c_save) ? rf_rd1 : 32'd0;
        rf_we     = (state_q == c_rst_wr);
        rf_wa     = rf_we ? idx_q : 5'd0;
        rf_wd     = rf_we ? data_q : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_context_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_context_sequencer
// Brief    : Directed bench with register-file and memory models around the sequencer.
// Revision : 1.0
// ============================================================================
module tb_regfile_context_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        save_start, restore_start, mem_ready;
    logic [31:0] base_addr;
    logic        busy, done, rf_own, rf_we, mem_req, mem_we;
    logic [4:0]  rf_ra1, rf_wa;
    logic [31:0] rf_rd1, rf_wd, mem_addr, mem_wdata, mem_rdata;

    logic        save_start2;
    logic        busy2, done2, rf_own2, rf_we2, mem_req2, mem_we2;
    logic [4:0]  rf_ra1_2, rf_wa2;
    logic [31:0] rf_rd1_2, rf_wd2, mem_addr2, mem_wdata2;

    logic [31:0] rf  [32];
    logic [31:0] mem [256];
    logic [1:0]  load_sel;
    int          wr_cnt, done_cnt, we_cnt, bad_wa;
    int          n_cmp, n_err, cyc, snap_done, snap_we, snap_wr;

    always #5 clk = ~clk;

    regfile_context_sequencer u_dut (
        .clk(clk), .reset(reset), .save_start(save_start), .restore_start(restore_start),
        .base_addr(base_addr), .busy(busy), .done(done), .rf_own(rf_own),
        .rf_ra1(rf_ra1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    regfile_context_sequencer #(.FIRST_REG(28), .LAST_REG(30), .ADDR_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .save_start(save_start2), .restore_start(1'b0),
        .base_addr(32'hFFFF_FFF8), .busy(busy2), .done(done2), .rf_own(rf_own2),
        .rf_ra1(rf_ra1_2), .rf_rd1(rf_rd1_2), .rf_we(rf_we2), .rf_wa(rf_wa2), .rf_wd(rf_wd2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(32'd0), .mem_ready(1'b1)
    );

    assign rf_rd1    = rf[rf_ra1];
    assign mem_rdata = mem[mem_addr[9:2]];
    assign rf_rd1_2  = 32'h100 + {27'd0, rf_ra1_2};

    // load_sel 1: rf = 0x100+i; 2: rf cleared, memory cleared with restore pattern at 0x300.
    always @(posedge clk) begin
        if (load_sel == 2'd1) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'h100 + i;
        end else if (load_sel == 2'd2) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            for (int i = 0; i < 256; i++) mem[i] <= (i >= 192 && i < 223) ? 32'hA000 + (i - 192) : 32'd0;
        end else begin
            if (rf_we) rf[rf_wa] <= rf_wd;
            if (mem_req && mem_ready && mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
        if (done)                done_cnt <= done_cnt + 1;
        if (rf_we)               we_cnt   <= we_cnt + 1;
        if (rf_we && rf_wa == 0) bad_wa   <= bad_wa + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic load(input logic [1:0] sel);
        load_sel = sel;
        @(negedge clk);
        load_sel = 2'd0;
    endtask

    task automatic start(input logic sv, input logic rs, input logic [31:0] base);
        save_start    = sv;
        restore_start = rs;
        base_addr     = base;
        cyc = 0;
        step();
        save_start    = 1'b0;
        restore_start = 1'b0;
    endtask

    task automatic wait_done();
        while (!done && cyc < 200) step();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        wr_cnt = 0; done_cnt = 0; we_cnt = 0; bad_wa = 0;
        reset = 1'b1; save_start = 1'b0; restore_start = 1'b0; save_start2 = 1'b0;
        mem_ready = 1'b1; base_addr = 32'd0; load_sel = 2'd0;
        @(negedge clk);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_own",     {31'd0, rf_own},  32'd0);
        check("rst_we",      {31'd0, rf_we},   32'd0);
        check("rst_req",     {31'd0, mem_req}, 32'd0);
        check("rst_addr",    mem_addr,         32'd0);
        check("rst_ra1_wa",  {22'd0, rf_ra1, rf_wa}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        load(2'd2);
        load(2'd1);

        // Full save at base 0x203 (aligned down to 0x200).
        snap_wr = wr_cnt;
        start(1'b1, 1'b0, 32'h203);
        check("s1_addr0",  mem_addr,  32'h200);
        check("s1_wdata0", mem_wdata, 32'h101);
        check("s1_ra0",    {27'd0, rf_ra1}, 32'd1);
        check("s1_we_own", {30'd0, mem_we, rf_own}, 32'd3);
        wait_done();
        check("s1_latency", cyc, 32);
        step();
        check("s1_idle", {30'd0, busy, done}, 32'd0);
        check("s1_writes", wr_cnt - snap_wr, 31);
        for (int i = 1; i < 32; i++) check($sformatf("s1_mem%0d", i), mem[127 + i], 32'h100 + i);
        check("s1_untouched", mem[159], 32'd0);

        // Full restore from 0x300.
        load(2'd2);
        start(1'b0, 1'b1, 32'h300);
        check("r2_rd0", {30'd0, mem_req, mem_we}, 32'd2);
        check("r2_addr0", mem_addr, 32'h300);
        wait_done();
        check("r2_latency", cyc, 63);
        for (int i = 1; i < 32; i++) check($sformatf("r2_rf%0d", i), rf[i], 32'hA000 + i - 1);
        check("r2_r0", rf[0], 32'd0);
        check("r2_wa0", bad_wa, 0);

        // Save with mem_ready low for three cycles on the second access.
        step(); step();
        load(2'd1);
        start(1'b1, 1'b0, 32'h200);
        step();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_addr%0d", k), mem_addr, 32'h204);
            check($sformatf("bp_wd%0d", k), mem_wdata, 32'h102);
            check($sformatf("bp_ra%0d", k), {27'd0, rf_ra1}, 32'd2);
            step();
        end
        mem_ready = 1'b1;
        check("bp_addr_rel", mem_addr, 32'h204);
        wait_done();
        check("bp_latency", cyc, 35);
        step(); step();

        // Both starts together: save wins; a re-start while busy is ignored.
        snap_done = done_cnt;
        snap_we   = we_cnt;
        start(1'b1, 1'b1, 32'h200);
        check("both_save", {31'd0, mem_we}, 32'd1);
        step(); step();
        save_start = 1'b1;
        step();
        save_start = 1'b0;
        wait_done();
        check("both_latency", cyc, 32);
        for (int k = 0; k < 4; k++) step();
        check("both_one_done", done_cnt - snap_done, 1);
        check("both_no_we",    we_cnt - snap_we, 0);

        // Reset during RST_WR of r5 aborts immediately.
        load(2'd1);
        start(1'b0, 1'b1, 32'h300);
        while (cyc < 10) step();
        check("ab_pre", {26'd0, rf_we, rf_wa}, {26'd0, 1'b1, 5'd5});
        #2 reset = 1'b1;
        #1;
        check("ab_drop", {29'd0, rf_we, mem_req, busy}, 32'd0);
        step();
        reset = 1'b0;
        check("ab_r5", rf[5], 32'h105);
        check("ab_r4", rf[4], 32'hA003);
        start(1'b0, 1'b1, 32'h300);
        check("ab_re_addr", mem_addr, 32'h300);
        step();
        check("ab_re_wa", {27'd0, rf_wa}, 32'd1);
        check("ab_re_wd", rf_wd, 32'hA000);
        wait_done();
        check("ab_re_latency", cyc, 63);
        step();

        // Narrow range with address wrap on the second instance.
        save_start2 = 1'b1;
        step();
        save_start2 = 1'b0;
        check("w_addr0", mem_addr2, 32'hFFFF_FFF8);
        check("w_data0", mem_wdata2, 32'h11C);
        step();
        check("w_addr1", mem_addr2, 32'hFFFF_FFFC);
        step();
        check("w_addr2", mem_addr2, 32'h0000_0000);
        check("w_ra2",   {27'd0, rf_ra1_2}, 32'd30);
        step();
        check("w_done",  {30'd0, done2, mem_req2}, 32'd2);
        step();
        check("w_idle",  {31'd0, busy2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
